alu_adder_hold: RTL and testbench
=================================

Name: alu_adder_hold

Overview:
- Upstream stage of decimal_adjust_adder.
- Performs the 8-bit ALU operation (sum, AND, EOR, OR, shift-right) and captures the result in the adder hold register.
- Generates the decimal carries (half_carry, alu_cout_n) and the daa_n/dsa_n strobes that the decimal adjust adders consume.
- Accepts operations over a valid/ready handshake and holds results under downstream back-pressure.

Parameters:
- WIDTH, 8, datapath width; the nibble split is fixed at bit 4, so only 8 is supported.

Ports:
- clk_2  in  1  phase-2 clock; all state updates on its rising edge.
- res_n  in  1  reset, synchronous, active-low.
- op_valid  in  1  operation request.
- op_ready  out  1  block can accept an operation.
- alu_op  in  3  0=SUMS, 1=ANDS, 2=EORS, 3=ORS, 4=SRS; 5-7 are treated as ORS.
- ai  in  8  A-input register value.
- bi  in  8  B-input register value; already inverted by the caller for SBC.
- carry_in  in  1  carry into bit 0, or the bit shifted into bit 7 for SRS.
- decimal_en  in  1  processor D flag, sampled at acceptance.
- subtract  in  1  1 = SBC; selects dsa_n instead of daa_n.
- result_valid  out  1  hold-register outputs are valid.
- result_ready  in  1  downstream consumed the result.
- alu_result  out  8  adder hold register.
- half_carry  out  1  carry from bit 3 to bit 4 (DC3), registered.
- alu_cout_n  out  1  inverted carry out (DC7), registered.
- overflow  out  1  signed overflow, registered.
- daa_n  out  1  decimal add adjust, active-low.
- dsa_n  out  1  decimal subtract adjust, active-low.

Behaviour:
- Reset: sampled on clk_2 while res_n=0; it overrides all other activity. Reset values:
  - state IDLE
  - alu_result 0x00, half_carry 0, alu_cout_n 1, overflow 0
  - daa_n 1, dsa_n 1, result_valid 0
  - op_ready is 1 from the first cycle after reset.
- Reset mid-operation: any in-flight operation is discarded and no result is presented.
- FSM has three states:
  - IDLE: op_ready=1. When op_valid=1, all inputs are latched into the hold registers at that edge and the state goes to HOLD.
  - HOLD: result_valid=1, op_ready=0. Outputs stay stable while result_ready=0.
    - On result_ready=1 with a decimal SUMS operation: go to ADJ.
    - On result_ready=1 otherwise: go to IDLE.
  - ADJ: result_valid=0, op_ready=0. daa_n/dsa_n remain asserted so that the adjust adder's clk_2 latch captures them. Always returns to IDLE after one cycle.
- Throughput: binary operation 2 cycles minimum; decimal operation 3 cycles minimum. op_valid is ignored outside IDLE; a request is neither queued nor lost-acknowledged.
- Decimal strobes:
  - A decimal operation is SUMS with decimal_en=1.
  - For a decimal operation, daa_n = subtract and dsa_n = ~subtract, asserted from the HOLD entry edge through the end of ADJ.
  - Both strobes are 1 at all other times.
- SUMS arithmetic:
  - Low nibble: l = ai[3:0] + bi[3:0] + carry_in (5 bits).
  - DC3 = l[4] | (decimal_en & ~subtract & l[3:0] > 9).
  - High nibble: h = ai[7:4] + bi[7:4] + DC3.
  - DC7 = h[4] | (decimal_en & ~subtract & h[3:0] > 9).
  - alu_result = {h[3:0], l[3:0]}, i.e. the raw binary bits with no adjustment.
  - half_carry = DC3; alu_cout_n = ~DC7.
  - overflow = ~(ai[7]^bi[7]) & (ai[7]^alu_result[7]).
- SRS: alu_result = {carry_in, ai[7:1]}; alu_cout_n = ~ai[0].
- ANDS/EORS/ORS: bitwise ai op bi.
- Non-sum operations: half_carry=0, overflow=0; alu_cout_n=1 except SRS.
- Wrap-around: the 8-bit result is truncated; the carry appears only on alu_cout_n.

Decomposition:
- Shared package alu_pkg:
  - alu_op encodings SUMS/ANDS/EORS/ORS/SRS.
  - FSM state enum IDLE/HOLD/ADJ.
  - Constant BCD_MAX_DIGIT=9.
- One sub-module, bcd_nibble_adder: inputs a[3:0], b[3:0], cin, dec_add; outputs s[3:0], cout with forcing. Instantiated twice (low and high nibble).

Test Plan:
- Binary add: ai=0x50, bi=0x50, cin=0, D=0 -> alu_result=0xA0, overflow=1, alu_cout_n=1, half_carry=0, daa_n=dsa_n=1; HOLD->IDLE.
- Decimal add: ai=0x19, bi=0x28, cin=0, D=1 -> alu_result=0x41, half_carry=1, alu_cout_n=1; daa_n=0 for 2 cycles; chained adjust adder outputs 0x47.
- Decimal add wrap: ai=0x99, bi=0x01, cin=0, D=1 -> alu_result=0xAA, half_carry=1, alu_cout_n=0; adjusted 0x00 with carry.
- Decimal sub: ai=0x10, bi=0xFE (~0x01), cin=1, subtract=1, D=1 -> alu_result=0x0F, half_carry=0, alu_cout_n=0, dsa_n=0; adjusted 0x09.
- Back-pressure: result_ready=0 for 3 cycles with op_valid=1 -> outputs stable, op_ready=0, second op not accepted until return to IDLE.
- Reset in ADJ: res_n=0 for one edge -> next cycle daa_n=1, dsa_n=1, result_valid=0, alu_result=0x00, op_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU / adder-hold stage and its decimal nibble adders.
package alu_pkg;

   localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

   typedef enum logic [2:0] {
      SUMS = 3'd0,
      ANDS = 3'd1,
      EORS = 3'd2,
      ORS  = 3'd3,
      SRS  = 3'd4
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      ADJ  = 2'd2
   } state_e;

endpackage

// File: rtl/bcd_nibble_adder.sv
// 4-bit adder whose carry is forced when a decimal add produces a digit above 9.
module bcd_nibble_adder
   import alu_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   input  logic       dec_add,
   output logic [3:0] s,
   output logic       cout
);

   logic [4:0] sum;

   assign sum  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
   assign s    = sum[3:0];
   assign cout = sum[4] | (dec_add & (sum[3:0] > BCD_MAX_DIGIT));

endmodule

// File: rtl/alu_adder_hold.sv
// ALU operation plus adder hold register with decimal carries and adjust strobes,
// behind a valid/ready handshake.
//
// state | meaning
// IDLE  | ready for an operation; inputs captured on op_valid
// HOLD  | result presented; held until result_ready
// ADJ   | one extra cycle keeping daa_n/dsa_n asserted for the adjust adder
module alu_adder_hold
   import alu_pkg::*;
#(
   parameter int WIDTH = 8   // nibble split fixed at bit 4; only 8 is meaningful
) (
   input  logic             clk_2,
   input  logic             res_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] ai,
   input  logic [WIDTH-1:0] bi,
   input  logic             carry_in,
   input  logic             decimal_en,
   input  logic             subtract,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] alu_result,
   output logic             half_carry,
   output logic             alu_cout_n,
   output logic             overflow,
   output logic             daa_n,
   output logic             dsa_n
);

   state_e           state_q, state_d;
   logic             dec_op_q;
   logic             load;
   logic             dec_add;
   logic             dec_op;
   logic [3:0]       lo_s, hi_s;
   logic             dc3, dc7;
   logic [WIDTH-1:0] nxt_result;
   logic             nxt_hc, nxt_cout_n, nxt_ovf;

   assign dec_add = decimal_en & ~subtract;
   assign dec_op  = (alu_op == SUMS) & decimal_en;

   bcd_nibble_adder u_lo (
      .a       (ai[3:0]),
      .b       (bi[3:0]),
      .cin     (carry_in),
      .dec_add (dec_add),
      .s       (lo_s),
      .cout    (dc3)
   );

   bcd_nibble_adder u_hi (
      .a       (ai[7:4]),
      .b       (bi[7:4]),
      .cin     (dc3),
      .dec_add (dec_add),
      .s       (hi_s),
      .cout    (dc7)
   );

   always_comb begin
      nxt_result = ai | bi;
      nxt_hc     = 1'b0;
      nxt_cout_n = 1'b1;
      nxt_ovf    = 1'b0;
      case (alu_op)
         SUMS: begin
            nxt_result = {hi_s, lo_s};
            nxt_hc     = dc3;
            nxt_cout_n = ~dc7;
            nxt_ovf    = ~(ai[7] ^ bi[7]) & (ai[7] ^ hi_s[3]);
         end
         ANDS:    nxt_result = ai & bi;
         EORS:    nxt_result = ai ^ bi;
         SRS: begin
            nxt_result = {carry_in, ai[7:1]};
            nxt_cout_n = ~ai[0];
         end
         default: nxt_result = ai | bi;   // ORS and the unused codes 5-7
      endcase
   end

   always_comb begin
      state_d      = state_q;
      load         = 1'b0;
      op_ready     = (state_q == IDLE);
      result_valid = (state_q == HOLD);
      case (state_q)
         IDLE: begin
            if (op_valid) begin
               load    = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (result_ready) state_d = dec_op_q ? ADJ : IDLE;
         end
         ADJ:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_2) begin
      if (!res_n) begin
         state_q    <= IDLE;
         dec_op_q   <= 1'b0;
         alu_result <= '0;
         half_carry <= 1'b0;
         alu_cout_n <= 1'b1;
         overflow   <= 1'b0;
         daa_n      <= 1'b1;
         dsa_n      <= 1'b1;
      end else begin
         state_q <= state_d;
         if (load) begin
            dec_op_q   <= dec_op;
            alu_result <= nxt_result;
            half_carry <= nxt_hc;
            alu_cout_n <= nxt_cout_n;
            overflow   <= nxt_ovf;
            daa_n      <= ~dec_op | subtract;
            dsa_n      <= ~dec_op | ~subtract;
         end else if (state_d == IDLE) begin
            // strobes span HOLD entry through the end of ADJ, then release
            daa_n <= 1'b1;
            dsa_n <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_adder_hold.sv
// Self-checking bench for alu_adder_hold: vector table, scoreboard queue, corner sequences.
module tb_alu_adder_hold;

   logic       clk_2 = 1'b0;
   logic       res_n;
   logic       op_valid;
   logic       op_ready;
   logic [2:0] alu_op;
   logic [7:0] ai, bi;
   logic       carry_in, decimal_en, subtract;
   logic       result_valid, result_ready;
   logic [7:0] alu_result;
   logic       half_carry, alu_cout_n, overflow, daa_n, dsa_n;

   alu_adder_hold #(.WIDTH(8)) dut (
      .clk_2        (clk_2),
      .res_n        (res_n),
      .op_valid     (op_valid),
      .op_ready     (op_ready),
      .alu_op       (alu_op),
      .ai           (ai),
      .bi           (bi),
      .carry_in     (carry_in),
      .decimal_en   (decimal_en),
      .subtract     (subtract),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .alu_result   (alu_result),
      .half_carry   (half_carry),
      .alu_cout_n   (alu_cout_n),
      .overflow     (overflow),
      .daa_n        (daa_n),
      .dsa_n        (dsa_n)
   );

   always #5 clk_2 = ~clk_2;

   typedef struct packed {
      logic [7:0] res;
      logic       hc, coutn, ovf, daa, dsa;
   } exp_t;

   typedef struct {
      logic [2:0] op;
      logic [7:0] a, b;
      logic       cin, dec, sub;
      exp_t       e;
   } vec_t;

   vec_t vecs[15];
   exp_t sb_q[$];
   exp_t cur_exp;
   int   passed = 0;
   int   total  = 0;

   // scoreboard push on every accepted operation
   always @(posedge clk_2)
      if (res_n && op_valid && op_ready) sb_q.push_back(cur_exp);

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input logic dec, input logic sub,
                               input logic [7:0] res, input logic hc, input logic coutn,
                               input logic ovf, input logic daa, input logic dsa);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.cin = cin; v.dec = dec; v.sub = sub;
      v.e = '{res: res, hc: hc, coutn: coutn, ovf: ovf, daa: daa, dsa: dsa};
      return v;
   endfunction

   task automatic wait_ready(input string nm);
      int n = 0;
      while (!op_ready && n < 10) begin
         @(negedge clk_2);
         n++;
      end
      if (!op_ready) check({nm, "_ready_timeout"}, 16'(op_ready), 16'd1);
   endtask

   task automatic drive(input vec_t v);
      alu_op = v.op; ai = v.a; bi = v.b;
      carry_in = v.cin; decimal_en = v.dec; subtract = v.sub;
      cur_exp = v.e;
   endtask

   task automatic check_out(input string nm);
      exp_t e;
      check({nm, "_sb_nonempty"}, 16'(sb_q.size() != 0), 16'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check({nm, "_result"}, 16'(alu_result), 16'(e.res));
         check({nm, "_flags"}, 16'({half_carry, alu_cout_n, overflow, daa_n, dsa_n}),
               16'({e.hc, e.coutn, e.ovf, e.daa, e.dsa}));
      end
   endtask

   // one full transaction; starts and ends on a negedge
   task automatic run_vec(input int i);
      string nm;
      logic  is_dec;
      nm = $sformatf("v%0d", i);
      is_dec = (vecs[i].op == 3'd0) && vecs[i].dec;
      wait_ready(nm);
      drive(vecs[i]);
      op_valid = 1'b1;
      @(posedge clk_2);
      @(negedge clk_2);
      op_valid = 1'b0;
      check({nm, "_valid"}, 16'({result_valid, op_ready}), 16'b10);
      check_out(nm);
      result_ready = 1'b1;
      @(posedge clk_2);
      @(negedge clk_2);
      result_ready = 1'b0;
      if (is_dec) begin
         check({nm, "_adj_hs"}, 16'({result_valid, op_ready}), 16'b00);
         check({nm, "_adj_strobe"}, 16'({daa_n, dsa_n}), 16'({vecs[i].e.daa, vecs[i].e.dsa}));
         @(negedge clk_2);
      end
      check({nm, "_idle_hs"}, 16'({result_valid, op_ready}), 16'b01);
      check({nm, "_idle_strobe"}, 16'({daa_n, dsa_n}), 16'b11);
   endtask

   initial begin
      vecs[0]  = mk(3'd0, 8'h50, 8'h50, 0, 0, 0, 8'hA0, 0, 1, 1, 1, 1);
      vecs[1]  = mk(3'd0, 8'h19, 8'h28, 0, 1, 0, 8'h41, 1, 1, 0, 0, 1);
      vecs[2]  = mk(3'd0, 8'h99, 8'h01, 0, 1, 0, 8'hAA, 1, 0, 0, 0, 1);
      vecs[3]  = mk(3'd0, 8'h10, 8'hFE, 1, 1, 1, 8'h0F, 0, 0, 0, 1, 0);
      vecs[4]  = mk(3'd0, 8'hFF, 8'h01, 0, 0, 0, 8'h00, 1, 0, 0, 1, 1);
      vecs[5]  = mk(3'd0, 8'h7F, 8'h00, 1, 0, 0, 8'h80, 1, 1, 1, 1, 1);
      vecs[6]  = mk(3'd1, 8'hF0, 8'h3C, 0, 0, 0, 8'h30, 0, 1, 0, 1, 1);
      vecs[7]  = mk(3'd2, 8'hF0, 8'h3C, 0, 0, 0, 8'hCC, 0, 1, 0, 1, 1);
      vecs[8]  = mk(3'd3, 8'h0F, 8'h30, 1, 0, 0, 8'h3F, 0, 1, 0, 1, 1);
      vecs[9]  = mk(3'd4, 8'h03, 8'h55, 1, 0, 0, 8'h81, 0, 0, 0, 1, 1);
      vecs[10] = mk(3'd4, 8'h82, 8'hFF, 0, 0, 0, 8'h41, 0, 1, 0, 1, 1);
      vecs[11] = mk(3'd7, 8'h12, 8'h21, 0, 0, 0, 8'h33, 0, 1, 0, 1, 1);
      vecs[12] = mk(3'd0, 8'h45, 8'h44, 0, 1, 0, 8'h89, 0, 1, 1, 0, 1);
      vecs[13] = mk(3'd1, 8'hF0, 8'hFF, 0, 1, 0, 8'hF0, 0, 1, 0, 1, 1);
      vecs[14] = mk(3'd0, 8'h50, 8'hAF, 1, 1, 1, 8'h00, 1, 0, 0, 1, 0);

      res_n = 1'b0; op_valid = 1'b0; result_ready = 1'b0;
      alu_op = 3'd0; ai = 8'h00; bi = 8'h00;
      carry_in = 1'b0; decimal_en = 1'b0; subtract = 1'b0; cur_exp = '0;
      repeat (2) @(negedge clk_2);
      res_n = 1'b1;
      check("reset_hs", 16'({result_valid, op_ready}), 16'b01);
      check("reset_out", 16'({alu_result, half_carry, alu_cout_n, overflow, daa_n, dsa_n}),
            16'({8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}));

      for (int i = 0; i < 15; i++) run_vec(i);

      // back-pressure: held result, competing request ignored until IDLE
      drive(vecs[0]);
      op_valid = 1'b1;
      @(posedge clk_2);
      @(negedge clk_2);
      drive(vecs[7]);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("bp%0d_hs", k), 16'({result_valid, op_ready}), 16'b10);
         check($sformatf("bp%0d_res", k), 16'(alu_result), 16'hA0);
         check($sformatf("bp%0d_ovf", k), 16'(overflow), 16'd1);
         @(negedge clk_2);
      end
      check_out("bp_first");
      result_ready = 1'b1;
      @(posedge clk_2);
      @(negedge clk_2);
      result_ready = 1'b0;
      check("bp_idle_hs", 16'({result_valid, op_ready}), 16'b01);
      @(posedge clk_2);
      @(negedge clk_2);
      op_valid = 1'b0;
      check("bp_second_hs", 16'({result_valid, op_ready}), 16'b10);
      check_out("bp_second");
      result_ready = 1'b1;
      @(posedge clk_2);
      @(negedge clk_2);
      result_ready = 1'b0;

      // reset while in ADJ
      drive(vecs[1]);
      op_valid = 1'b1;
      @(posedge clk_2);
      @(negedge clk_2);
      op_valid = 1'b0;
      check_out("radj");
      result_ready = 1'b1;
      @(posedge clk_2);
      @(negedge clk_2);
      result_ready = 1'b0;
      check("radj_in_adj", 16'({result_valid, op_ready, daa_n}), 16'b000);
      res_n = 1'b0;
      @(posedge clk_2);
      @(negedge clk_2);
      res_n = 1'b1;
      check("radj_hs", 16'({result_valid, op_ready}), 16'b01);
      check("radj_out", 16'({alu_result, half_carry, alu_cout_n, overflow, daa_n, dsa_n}),
            16'({8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}));

      // reset while holding: result discarded
      drive(vecs[3]);
      op_valid = 1'b1;
      @(posedge clk_2);
      @(negedge clk_2);
      op_valid = 1'b0;
      check("rhold_hs", 16'({result_valid, dsa_n}), 16'b10);
      res_n = 1'b0;
      @(posedge clk_2);
      @(negedge clk_2);
      res_n = 1'b1;
      sb_q.delete();
      check("rhold_after", 16'({result_valid, op_ready, daa_n, dsa_n}), 16'b0111);
      check("rhold_res", 16'(alu_result), 16'h00);

      run_vec(2);
      check("sb_drained", 16'(sb_q.size()), 16'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
